fft_peak_finder: RTL and testbench
==================================

# fft_peak_finder

Consumer end of the magnitude stream produced by the FFT filter stage. Accepts one 64-bit squared-magnitude word per FFT bin under a valid/ready handshake, tracks the largest bin inside a configurable search window across each frame, and reports that bin index and magnitude once per frame to the pitch/display logic downstream.

## Interface

Parameters:
- FFT_POINTS, 1024, bins per frame; power of two.
- MIN_BIN, 2, lowest bin searched; skips DC and the first bin.
- MAX_BIN, 511, highest bin searched; first half only, because the input is real.
- THRESH, 64'd4096, minimum peak magnitude for a detection.

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  upstream valid; `mag` holds a bin when high.
- mag  in  64  squared magnitude (re² + im²), unsigned.
- done  out  1  ready to upstream; a bin is accepted on a cycle with `start && done`.
- peak_valid  out  1  one-cycle pulse; the result outputs are updated.
- peak_found  out  1  the frame maximum is at or above THRESH.
- peak_bin  out  10  bin index of the reported peak (log2 FFT_POINTS).
- peak_mag  out  64  magnitude of the frame maximum.

## Operation

- Reset values, applied on the first edge with `reset_n` low:
  - done=0, peak_valid=0, peak_found=0, peak_bin=0, peak_mag=0.
  - State=IDLE, bin counter=0, running max=0, history cleared.
- States:
  - IDLE: done=1. The first accepted bin moves to ACCUM. Counting starts at bin 0, and this bin is processed as bin 0.
  - ACCUM: done=1. Each accepted bin increments the bin counter.
    - If MIN_BIN ≤ counter ≤ MAX_BIN and mag > running max (strict), then running max←mag and max_bin←counter.
    - Ties resolve to the lowest bin.
    - When bin FFT_POINTS−1 is accepted, go to REPORT.
  - REPORT: done=0 for exactly one cycle.
    - Register the results: peak_found = (running max ≥ THRESH), peak_mag = running max, peak_bin = max_bin if found, else 0.
    - Pulse peak_valid.
    - Clear the running max, max_bin and counter, then return to IDLE.
- Bins outside the window are counted but never compared.
- Upstream stalls (`start` low) hold all state. There is no timeout.
- Counter wrap: the counter never exceeds FFT_POINTS−1. REPORT always intervenes before the next frame.
- Reset mid-frame discards the partial frame. No peak_valid is produced for it.
- Results hold their value between pulses.

## Timing

- Result latency: peak_valid is high in the cycle after the edge that accepted the last bin. That is one cycle of latency.
- done is low during that same cycle. No bin can be accepted while the result is being reported.
- Throughput: FFT_POINTS+1 cycles per frame at a continuous `start`.
- Comparison and update are single-cycle. There is no pipelining of `mag`.

## Configuration

- PEAK_MEDIAN_EN, defined:
  - Keep a 3-entry history of raw per-frame peak_bin values.
  - Report the median of the last three entries.
  - Frames with peak_found=0 push bin 0 into the history.
  - Until three frames have been seen, report the raw bin.
  - peak_mag and peak_found are always the current frame's values.
  - Latency is unchanged: the median is combinational on the registered history, and the output is registered in REPORT.
- PEAK_MEDIAN_EN, undefined: peak_bin is the raw per-frame bin. No history registers exist.

## Structure

- Shared package `tuner_pkg` holds:
  - FFT_POINTS, BIN_W = $clog2(FFT_POINTS), MAG_W = 64.
  - The state enum: IDLE, ACCUM, REPORT.
  - These are shared with the filter stage and the display logic.
- One sub-module, `median3`: combinational median of three BIN_W-bit values. It is instantiated only under PEAK_MEDIAN_EN.

## Test plan

1. **Single peak.** Stream a frame with all bins mag=10, except bin 100 mag=1,000,000. Expect peak_valid for one cycle, peak_bin=100, peak_mag=1,000,000, peak_found=1. done must be low only during the pulse.
2. **Window exclusion and ties.** Bin 0 mag=2^40, bin 600 mag=2^40, bins 50 and 70 mag=5,000, everything else 0. Expect peak_bin=50, peak_mag=5,000.
3. **Below threshold.** All bins mag=100. Expect peak_found=0, peak_bin=0, peak_mag=100.
4. **Backpressure and stall.** Toggle `start` randomly at 50% duty with a peak at bin 300. Expect peak_bin=300 and exactly FFT_POINTS accepted bins before peak_valid.
5. **Reset mid-frame.** Assert reset_n=0 for one cycle after 500 bins with a peak at bin 10, then stream a full frame with its peak at bin 200. Expect no pulse for the aborted frame and peak_bin=200 for the second.
6. **Median, PEAK_MEDIAN_EN defined.** Four frames with peaks at bins 100, 300, 102, 104. Expect reported bins 100, 300, 102, 104.
   - Frames 1–2 report the raw bin (history not yet full).
   - Frame 3 reports the median of {100, 300, 102} = 102.
   - Frame 4 reports the median of {300, 102, 104} = 104.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared tuner types: FFT sizing, magnitude width and the peak finder states.
package tuner_pkg;

    localparam int FFT_POINTS = 1024;
    localparam int BIN_W      = $clog2(FFT_POINTS);
    localparam int MAG_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

endpackage

// File: rtl/median3.sv
// Combinational median of three bin indices.
module median3
    import tuner_pkg::*;
#(
    parameter int W = BIN_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] med
);

    logic [W-1:0] lo_ab;
    logic [W-1:0] hi_ab;
    logic [W-1:0] lo_hc;

    always_comb begin
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        lo_hc = (hi_ab < c) ? hi_ab : c;
        med   = (lo_ab > lo_hc) ? lo_ab : lo_hc;
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame windowed peak search over the FFT magnitude stream.
// Define PEAK_MEDIAN_EN to report the median bin of the last three frames.
module fft_peak_finder #(
    parameter int          FFT_POINTS = 1024,
    parameter int          MIN_BIN    = 2,
    parameter int          MAX_BIN    = 511,
    parameter logic [63:0] THRESH     = 64'd4096
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [63:0]                   mag,
    output logic                          done,
    output logic                          peak_valid,
    output logic                          peak_found,
    output logic [$clog2(FFT_POINTS)-1:0] peak_bin,
    output logic [63:0]                   peak_mag
);

    import tuner_pkg::*;

    localparam int BW = $clog2(FFT_POINTS);
    localparam logic [BW-1:0] LO_BIN  = BW'(MIN_BIN);
    localparam logic [BW-1:0] HI_BIN  = BW'(MAX_BIN);
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_POINTS - 1);

    state_t           state;
    state_t           state_n;
    logic [BW-1:0]    cnt;
    logic [MAG_W-1:0] run_max;
    logic [BW-1:0]    max_bin;

    logic             acc;
    logic             last;
    logic             upd;
    logic [MAG_W-1:0] max_n;
    logic [BW-1:0]    bin_n;
    logic             found_n;
    logic [BW-1:0]    raw_n;
    logic [BW-1:0]    rep_bin;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (acc) state_n = last ? REPORT : ACCUM;
            ACCUM:   if (last) state_n = REPORT;
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The last bin folds into the result on its own accept edge,
    // so the pulse lands in the REPORT cycle.
    always_comb begin
        acc     = start && done && (state != REPORT);
        last    = acc && (cnt == LAST_BIN);
        upd     = acc && (cnt >= LO_BIN) && (cnt <= HI_BIN)
                  && (mag > run_max);
        max_n   = upd ? mag : run_max;
        bin_n   = upd ? cnt : max_bin;
        found_n = (max_n >= THRESH);
        raw_n   = found_n ? bin_n : '0;
    end

`ifdef PEAK_MEDIAN_EN
    logic [BW-1:0] hist0;
    logic [BW-1:0] hist1;
    logic [1:0]    seen;
    logic [BW-1:0] med;

    median3 #(.W(BW)) u_median3 (
        .a   (raw_n),
        .b   (hist0),
        .c   (hist1),
        .med (med)
    );

    always_comb rep_bin = (seen == 2'd2) ? med : raw_n;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            hist0 <= '0;
            hist1 <= '0;
            seen  <= '0;
        end else if (last) begin
            hist0 <= raw_n;
            hist1 <= hist0;
            if (seen != 2'd2) seen <= seen + 2'd1;
        end
    end
`else
    always_comb rep_bin = raw_n;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            done       <= 1'b0;
            peak_valid <= 1'b0;
            peak_found <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            cnt        <= '0;
            run_max    <= '0;
            max_bin    <= '0;
        end else begin
            done       <= (state_n != REPORT);
            peak_valid <= last;
            if (state == REPORT) begin
                cnt     <= '0;
                run_max <= '0;
                max_bin <= '0;
            end else if (acc) begin
                cnt     <= cnt + 1'b1;
                run_max <= max_n;
                max_bin <= bin_n;
            end
            if (last) begin
                peak_found <= found_n;
                peak_mag   <= max_n;
                peak_bin   <= rep_bin;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder with hand-computed expectations.
// Define PEAK_MEDIAN_EN to add the median-history frames.
module tb_fft_peak_finder;

    localparam int N = 1024;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [63:0] mag      = '0;
    logic        done;
    logic        peak_valid;
    logic        peak_found;
    logic [9:0]  peak_bin;
    logic [63:0] peak_mag;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int acc_cnt  = 0;
    logic [63:0] mags [N];

    fft_peak_finder dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .start      (start),
        .mag        (mag),
        .done       (done),
        .peak_valid (peak_valid),
        .peak_found (peak_found),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (peak_valid === 1'b1) pulses++;

    // Accepted bins since the last pulse or reset.
    always @(posedge CLOCK_50) begin
        if (!reset_n || peak_valid) acc_cnt = 0;
        else if (start && done) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [63:0] bg);
        for (int i = 0; i < N; i++) mags[i] = bg;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        start   = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic run_frame(input string tag, input bit rnd,
                             input int nbins);
        int i = 0;
        int guard = 0;
        while (i < nbins && guard < 20000) begin
            @(negedge CLOCK_50);
            guard++;
            if (rnd && $urandom_range(0, 1) == 0) begin
                start = 1'b0;
            end else begin
                start = 1'b1;
                mag   = mags[i];
            end
            if (start && done) i++;
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        if (guard >= 20000) chk({tag, "_timeout"}, 64'(i), 64'(nbins));
    endtask

    task automatic check_result(input string tag, input logic [63:0] bin,
                                input logic [63:0] m, input logic f);
        chk({tag, "_pv"}, 64'(peak_valid), 64'd1);
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
        chk({tag, "_bin"}, 64'(peak_bin), bin);
        chk({tag, "_mag"}, peak_mag, m);
        chk({tag, "_found"}, 64'(peak_found), 64'(f));
        @(negedge CLOCK_50);
        chk({tag, "_pv_off"}, 64'(peak_valid), 64'd0);
        chk({tag, "_done_hi"}, 64'(done), 64'd1);
        chk({tag, "_bin_hold"}, 64'(peak_bin), bin);
    endtask

    initial begin
        int p0;

        // Reset state
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pv", 64'(peak_valid), 64'd0);
        chk("rst_found", 64'(peak_found), 64'd0);
        chk("rst_bin", 64'(peak_bin), 64'd0);
        chk("rst_mag", peak_mag, 64'd0);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        chk("idle_done", 64'(done), 64'd1);

        // Single peak
        fill(64'd10);
        mags[100] = 64'd1000000;
        p0 = pulses;
        run_frame("t1", 1'b0, N);
        check_result("t1", 64'd100, 64'd1000000, 1'b1);
        chk("t1_pulses", 64'(pulses - p0), 64'd1);

        // Window exclusion and ties
        do_reset();
        fill(64'd0);
        mags[0]   = 64'd1 << 40;
        mags[600] = 64'd1 << 40;
        mags[50]  = 64'd5000;
        mags[70]  = 64'd5000;
        run_frame("t2", 1'b0, N);
        check_result("t2", 64'd50, 64'd5000, 1'b1);

        // Below threshold
        do_reset();
        fill(64'd100);
        run_frame("t3", 1'b0, N);
        check_result("t3", 64'd0, 64'd100, 1'b0);

        // Backpressure and stall
        do_reset();
        fill(64'd10);
        mags[300] = 64'd777777;
        run_frame("t4", 1'b1, N);
        chk("t4_accepted", 64'(acc_cnt), 64'(N));
        check_result("t4", 64'd300, 64'd777777, 1'b1);

        // Reset mid-frame
        do_reset();
        fill(64'd10);
        mags[10] = 64'd900000;
        p0 = pulses;
        run_frame("t5a", 1'b0, 500);
        chk("t5_no_pv_partial", 64'(peak_valid), 64'd0);
        do_reset();
        chk("t5_no_pulse", 64'(pulses - p0), 64'd0);
        chk("t5_rst_mag", peak_mag, 64'd0);
        fill(64'd10);
        mags[200] = 64'd123456;
        run_frame("t5b", 1'b0, N);
        check_result("t5", 64'd200, 64'd123456, 1'b1);
        chk("t5_pulses", 64'(pulses - p0), 64'd1);

`ifdef PEAK_MEDIAN_EN
        // Median over frames 100, 300, 102, 104
        do_reset();
        fill(64'd10);
        mags[100] = 64'd1000000;
        run_frame("m1", 1'b0, N);
        check_result("m1", 64'd100, 64'd1000000, 1'b1);
        fill(64'd10);
        mags[300] = 64'd1000000;
        run_frame("m2", 1'b0, N);
        check_result("m2", 64'd300, 64'd1000000, 1'b1);
        fill(64'd10);
        mags[102] = 64'd1000000;
        run_frame("m3", 1'b0, N);
        check_result("m3", 64'd102, 64'd1000000, 1'b1);
        fill(64'd10);
        mags[104] = 64'd1000000;
        run_frame("m4", 1'b0, N);
        check_result("m4", 64'd104, 64'd1000000, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
